// File: rtl/controller_packet_tx_pkg.sv
// ---------------------------------------------------------------------------
// controller_packet_tx_pkg
//   Shared definitions for the controller packet link. The receive-side
//   parser imports the same package, so the state encodings, the packet
//   length and the default header byte live here rather than in either end.
//
//   Contents:
//     tx_state_t      transmit FSM state encoding
//     PKT_LEN         bytes per packet (header, buttons, sequence, checksum)
//     DEFAULT_HEADER  default first byte of every packet
//     tx_dbg_t        debug view of the transmit FSM and its bookkeeping
// ---------------------------------------------------------------------------
package controller_packet_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_READY = 3'd1,
        ST_STROBE     = 3'd2,
        ST_WAIT_DONE  = 3'd3,
        ST_FINISH     = 3'd4
    } tx_state_t;

    localparam int unsigned PKT_LEN        = 4;
    localparam logic [7:0]  DEFAULT_HEADER = 8'hA5;

    typedef struct packed {
        tx_state_t  state;
        logic [1:0] idx;
        logic [7:0] seq;
        logic       pending;
    } tx_dbg_t;

endpackage

// File: rtl/controller_packet_tx.sv
// ---------------------------------------------------------------------------
// controller_packet_tx
//   Frames the controller button state into a 4-byte packet and feeds it one
//   byte at a time to a UART transmitter:
//     byte 0  c_HEADER
//     byte 1  button snapshot taken when the request is accepted
//     byte 2  8-bit sequence number (advances only on a completed packet)
//     byte 3  XOR of bytes 0..2
//
//   Ports:
//     i_CLK        system clock, rising edge
//     i_RESET      asynchronous, active-high reset
//     i_BUTTONS    button state, synchronous to i_CLK
//     i_SEND       packet request, sampled every cycle
//     i_TX_ACTIVE  UART transmitter busy
//     i_TX_DONE    UART transmitter finished the current byte (1-cycle pulse)
//     o_TX_DV      data-valid strobe to the UART transmitter (1-cycle pulse)
//     o_TX_BYTE    byte to the UART transmitter, held until the next strobe
//     o_BUSY       packet in progress (every state but IDLE)
//     o_PKT_DONE   1-cycle pulse once the last byte has been transmitted
//     o_ERROR      1-cycle pulse when a byte was not completed in time
//     o_DBG        FSM state, byte index, sequence number and pending flag
//
//   Handshake with the UART transmitter: a byte is offered only when
//   i_TX_ACTIVE is low; o_TX_DV is high for exactly one cycle and the byte on
//   o_TX_BYTE is valid in that cycle and stays put afterwards. The byte is
//   finished only by an i_TX_DONE pulse seen while waiting for it; a done
//   pulse at any other time carries no meaning and is dropped. A done pulse
//   arriving in the same cycle as the timeout still counts as success.
// ---------------------------------------------------------------------------
module controller_packet_tx
    import controller_packet_tx_pkg::*;
#(
    parameter logic [7:0]  c_HEADER         = DEFAULT_HEADER,
    parameter int unsigned c_TIMEOUT_CYCLES = 8192
) (
    input  logic       i_CLK,
    input  logic       i_RESET,
    input  logic [7:0] i_BUTTONS,
    input  logic       i_SEND,
    input  logic       i_TX_ACTIVE,
    input  logic       i_TX_DONE,
    output logic       o_TX_DV,
    output logic [7:0] o_TX_BYTE,
    output logic       o_BUSY,
    output logic       o_PKT_DONE,
    output logic       o_ERROR,
    output tx_dbg_t    o_DBG
);

    // Counter must be able to hold c_TIMEOUT_CYCLES itself.
    localparam int unsigned TO_W     = $clog2(c_TIMEOUT_CYCLES + 1);
    localparam logic [1:0]  LAST_IDX = 2'(PKT_LEN - 1);

    tx_state_t       state;
    tx_state_t       state_nxt;
    logic [1:0]      idx_q;
    logic [7:0]      snap_q;
    logic [7:0]      seq_q;
    logic [7:0]      byte_q;
    logic            pending_q;
    logic            err_q;
    logic [TO_W-1:0] to_cnt_q;
    logic            timeout;
    logic [7:0]      byte_mux;

    // The counter holds the number of WAIT_DONE cycles already spent, so the
    // last permitted cycle is the one where it reads c_TIMEOUT_CYCLES-1.
    assign timeout = (to_cnt_q == TO_W'(c_TIMEOUT_CYCLES - 1));

    // Byte selection and checksum.
    always_comb begin
        byte_mux = c_HEADER;
        case (idx_q)
            2'd0:    byte_mux = c_HEADER;
            2'd1:    byte_mux = snap_q;
            2'd2:    byte_mux = seq_q;
            default: byte_mux = c_HEADER ^ snap_q ^ seq_q;
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM state register
    // ---------------------------------------------------------------------
    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // FSM next state and state-decoded outputs
    // ---------------------------------------------------------------------
    always_comb begin
        state_nxt  = state;
        o_TX_DV    = 1'b0;
        o_BUSY     = 1'b1;
        o_PKT_DONE = 1'b0;
        case (state)
            ST_IDLE: begin
                o_BUSY = 1'b0;
                if (i_SEND || pending_q) begin
                    state_nxt = ST_WAIT_READY;
                end
            end
            ST_WAIT_READY: begin
                if (!i_TX_ACTIVE) begin
                    state_nxt = ST_STROBE;
                end
            end
            ST_STROBE: begin
                o_TX_DV   = 1'b1;
                state_nxt = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                // Done is checked before timeout so a coincident done wins.
                if (i_TX_DONE) begin
                    state_nxt = (idx_q == LAST_IDX) ? ST_FINISH : ST_WAIT_READY;
                end else if (timeout) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_FINISH: begin
                o_PKT_DONE = 1'b1;
                state_nxt  = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath: index, snapshot, sequence, pending flag, timeout, error
    // ---------------------------------------------------------------------
    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            idx_q     <= 2'd0;
            snap_q    <= 8'h00;
            seq_q     <= 8'h00;
            byte_q    <= 8'h00;
            pending_q <= 1'b0;
            err_q     <= 1'b0;
            to_cnt_q  <= '0;
        end else begin
            err_q <= 1'b0;

            // Requests seen while busy collapse into a single pending packet.
            if (state == ST_IDLE) begin
                if (i_SEND || pending_q) begin
                    idx_q     <= 2'd0;
                    snap_q    <= i_BUTTONS;
                    pending_q <= 1'b0;
                end
            end else if (i_SEND) begin
                pending_q <= 1'b1;
            end

            // Load the output byte on the way into STROBE so it is valid
            // together with the strobe and then held.
            if (state == ST_WAIT_READY && !i_TX_ACTIVE) begin
                byte_q <= byte_mux;
            end

            // STROBE always precedes WAIT_DONE, so clearing here is the
            // clear-on-entry.
            if (state == ST_STROBE) begin
                to_cnt_q <= '0;
            end else if (state == ST_WAIT_DONE) begin
                to_cnt_q <= to_cnt_q + TO_W'(1);
            end

            if (state == ST_WAIT_DONE) begin
                if (i_TX_DONE) begin
                    if (idx_q != LAST_IDX) begin
                        idx_q <= idx_q + 2'd1;
                    end
                end else if (timeout) begin
                    // Abandoned packet: drop any request queued behind it.
                    err_q     <= 1'b1;
                    pending_q <= 1'b0;
                end
            end

            if (state == ST_FINISH) begin
                seq_q <= seq_q + 8'd1;
            end
        end
    end

    assign o_TX_BYTE = byte_q;
    assign o_ERROR   = err_q;

    assign o_DBG = '{state: state, idx: idx_q, seq: seq_q, pending: pending_q};

endmodule
